axi_slave_mux_w: RTL and testbench

Write-path counterpart of the interconnect's read-side slave mux. It routes one AXI master's write transactions (AW, W, B handshakes) to one of two slaves, or to an internal decode-error responder, using an address decode latched at the AW handshake. One write transaction is outstanding at a time. AW payload (address, length, size, burst) and W payload (WDATA, WSTRB, WUSER) are broadcast to both slaves outside this block; only the valid/ready handshakes and the B response pass through it.

---
 rtl/axi_slave_mux_w.sv | 158 +++++++++++++++
 tb/tb_axi_slave_mux_w.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_slave_mux_w.sv
// Write-path slave mux: routes one outstanding AW/W/B transaction to slave 0, slave 1
// or an internal DECERR responder, using the address decode captured at the AW handshake.
module axi_slave_mux_w #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    ID_WIDTH   = 1,
    parameter int                    USER_WIDTH = 1,
    parameter logic [ADDR_WIDTH-1:0] S0_BASE    = 32'h0000_0000,
    parameter logic [ADDR_WIDTH-1:0] S0_MASK    = 32'hF000_0000,
    parameter logic [ADDR_WIDTH-1:0] S1_BASE    = 32'h1000_0000,
    parameter logic [ADDR_WIDTH-1:0] S1_MASK    = 32'hF000_0000
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic [ADDR_WIDTH-1:0] s_AWADDR,
    input  logic [ID_WIDTH-1:0]   s_AWID,
    input  logic                  s_AWVALID,
    input  logic                  s_WVALID,
    input  logic                  s_WLAST,
    input  logic                  s_BREADY,
    output logic                  m_AWREADY,
    output logic                  m_WREADY,
    output logic [ID_WIDTH-1:0]   m_BID,
    output logic [1:0]            m_BRESP,
    output logic [USER_WIDTH-1:0] m_BUSER,
    output logic                  m_BVALID,
    output logic                  s0_AWVALID,
    output logic                  s0_WVALID,
    output logic                  s0_BREADY,
    input  logic                  s0_AWREADY,
    input  logic                  s0_WREADY,
    input  logic                  s0_BVALID,
    input  logic [ID_WIDTH-1:0]   s0_BID,
    input  logic [1:0]            s0_BRESP,
    input  logic [USER_WIDTH-1:0] s0_BUSER,
    output logic                  s1_AWVALID,
    output logic                  s1_WVALID,
    output logic                  s1_BREADY,
    input  logic                  s1_AWREADY,
    input  logic                  s1_WREADY,
    input  logic                  s1_BVALID,
    input  logic [ID_WIDTH-1:0]   s1_BID,
    input  logic [1:0]            s1_BRESP,
    input  logic [USER_WIDTH-1:0] s1_BUSER,
    output logic [1:0]            dbg_state_o
);
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_DATA = 2'd1, ST_RESP = 2'd2} state_e;
    typedef enum logic [1:0] {SEL_S0 = 2'd0, SEL_S1 = 2'd1, SEL_ERR = 2'd2} sel_e;

    state_e              state_q, state_d;
    sel_e                sel_q, sel_d, dec_sel;
    logic [ID_WIDTH-1:0] err_id_q, err_id_d;
    logic                hit0, hit1;

    assign hit0 = ((s_AWADDR & S0_MASK) == S0_BASE);
    assign hit1 = ((s_AWADDR & S1_MASK) == S1_BASE);

    always_comb begin
        dec_sel = SEL_ERR;
        if (hit0)      dec_sel = SEL_S0;
        else if (hit1) dec_sel = SEL_S1;
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q  <= ST_IDLE;
            sel_q    <= SEL_S0;
            err_id_q <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            err_id_q <= err_id_d;
        end
    end

    // Every channel uses valid/ready: a transfer happens in the cycle where both are high;
    // all valid/ready paths are combinational and the unselected slave always sees 0.
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        err_id_d    = err_id_q;
        m_AWREADY   = 1'b0;
        m_WREADY    = 1'b0;
        m_BID       = '0;
        m_BRESP     = 2'b00;
        m_BUSER     = '0;
        m_BVALID    = 1'b0;
        s0_AWVALID  = 1'b0;
        s0_WVALID   = 1'b0;
        s0_BREADY   = 1'b0;
        s1_AWVALID  = 1'b0;
        s1_WVALID   = 1'b0;
        s1_BREADY   = 1'b0;
        dbg_state_o = 2'b00;
        // Outputs are held at 0 for the whole time reset is asserted.
        if (ARESETn) begin
            dbg_state_o = state_q;
            case (state_q)
                ST_IDLE: begin
                    case (dec_sel)
                        SEL_S0: begin
                            s0_AWVALID = s_AWVALID;
                            m_AWREADY  = s0_AWREADY;
                        end
                        SEL_S1: begin
                            s1_AWVALID = s_AWVALID;
                            m_AWREADY  = s1_AWREADY;
                        end
                        default: m_AWREADY = 1'b1;
                    endcase
                    if (s_AWVALID && m_AWREADY) begin
                        state_d  = ST_DATA;
                        sel_d    = dec_sel;
                        err_id_d = s_AWID;
                    end
                end
                ST_DATA: begin
                    case (sel_q)
                        SEL_S0: begin
                            s0_WVALID = s_WVALID;
                            m_WREADY  = s0_WREADY;
                        end
                        SEL_S1: begin
                            s1_WVALID = s_WVALID;
                            m_WREADY  = s1_WREADY;
                        end
                        default: m_WREADY = 1'b1;
                    endcase
                    if (s_WVALID && m_WREADY && s_WLAST) state_d = ST_RESP;
                end
                ST_RESP: begin
                    case (sel_q)
                        SEL_S0: begin
                            m_BVALID  = s0_BVALID;
                            m_BID     = s0_BID;
                            m_BRESP   = s0_BRESP;
                            m_BUSER   = s0_BUSER;
                            s0_BREADY = s_BREADY;
                        end
                        SEL_S1: begin
                            m_BVALID  = s1_BVALID;
                            m_BID     = s1_BID;
                            m_BRESP   = s1_BRESP;
                            m_BUSER   = s1_BUSER;
                            s1_BREADY = s_BREADY;
                        end
                        default: begin
                            m_BVALID = 1'b1;
                            m_BID    = err_id_q;
                            m_BRESP  = 2'b11;
                        end
                    endcase
                    if (m_BVALID && s_BREADY) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_slave_mux_w.sv
// Directed bench for axi_slave_mux_w: decode table in IDLE plus hand-written
// transaction sequences (burst stall, DECERR, B backpressure, mid-burst reset, early W).
module tb_axi_slave_mux_w;
    localparam logic [1:0] IDLE = 2'd0, DATA = 2'd1, RESP = 2'd2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] s_awaddr;
    logic [0:0]  s_awid;
    logic        s_awvalid, s_wvalid, s_wlast, s_bready;
    logic        m_awready, m_wready, m_bvalid;
    logic [0:0]  m_bid, m_buser;
    logic [1:0]  m_bresp;
    logic        s0_awvalid, s0_wvalid, s0_bready, s0_awready, s0_wready, s0_bvalid;
    logic [0:0]  s0_bid, s0_buser;
    logic [1:0]  s0_bresp;
    logic        s1_awvalid, s1_wvalid, s1_bready, s1_awready, s1_wready, s1_bvalid;
    logic [0:0]  s1_bid, s1_buser;
    logic [1:0]  s1_bresp;
    logic [1:0]  dbg_state;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    axi_slave_mux_w dut (
        .ACLK(clk), .ARESETn(rst_n),
        .s_AWADDR(s_awaddr), .s_AWID(s_awid), .s_AWVALID(s_awvalid),
        .s_WVALID(s_wvalid), .s_WLAST(s_wlast), .s_BREADY(s_bready),
        .m_AWREADY(m_awready), .m_WREADY(m_wready), .m_BID(m_bid),
        .m_BRESP(m_bresp), .m_BUSER(m_buser), .m_BVALID(m_bvalid),
        .s0_AWVALID(s0_awvalid), .s0_WVALID(s0_wvalid), .s0_BREADY(s0_bready),
        .s0_AWREADY(s0_awready), .s0_WREADY(s0_wready), .s0_BVALID(s0_bvalid),
        .s0_BID(s0_bid), .s0_BRESP(s0_bresp), .s0_BUSER(s0_buser),
        .s1_AWVALID(s1_awvalid), .s1_WVALID(s1_wvalid), .s1_BREADY(s1_bready),
        .s1_AWREADY(s1_awready), .s1_WREADY(s1_wready), .s1_BVALID(s1_bvalid),
        .s1_BID(s1_bid), .s1_BRESP(s1_bresp), .s1_BUSER(s1_buser),
        .dbg_state_o(dbg_state)
    );

    typedef struct {
        logic [31:0] addr;
        logic        s0_rdy;
        logic        s1_rdy;
        logic        exp_s0_v;
        logic        exp_s1_v;
        logic        exp_m_rdy;
    } dec_vec_t;

    dec_vec_t dec_tab[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        s_awaddr = '0; s_awid = '0; s_awvalid = 0; s_wvalid = 0; s_wlast = 0; s_bready = 0;
        s0_awready = 0; s0_wready = 0; s0_bvalid = 0; s0_bid = '0; s0_bresp = '0; s0_buser = '0;
        s1_awready = 0; s1_wready = 0; s1_bvalid = 0; s1_bid = '0; s1_bresp = '0; s1_buser = '0;
    endtask

    task automatic check_s0_quiet(input string tag);
        check({tag, ".s0_quiet"}, {29'd0, s0_awvalid, s0_wvalid, s0_bready}, 32'd0);
    endtask

    task automatic check_s1_quiet(input string tag);
        check({tag, ".s1_quiet"}, {29'd0, s1_awvalid, s1_wvalid, s1_bready}, 32'd0);
    endtask

    function automatic logic [31:0] all_outputs();
        return {19'd0, m_awready, m_wready, m_bid, m_bresp, m_buser, m_bvalid,
                s0_awvalid, s0_wvalid, s0_bready, s1_awvalid, s1_wvalid, s1_bready, dbg_state};
    endfunction

    initial begin
        int hs;
        int beat;
        int stall;

        dec_tab[0] = '{32'h0000_0040, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        dec_tab[1] = '{32'h0FFF_FFFC, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        dec_tab[2] = '{32'h1000_0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        dec_tab[3] = '{32'h1FFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        dec_tab[4] = '{32'h2000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        dec_tab[5] = '{32'hF000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        clear_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1 check("reset_outputs", all_outputs(), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("post_reset_state", {30'd0, dbg_state}, IDLE);

        // decode table: AWVALID is raised and dropped between rising edges, so no handshake
        foreach (dec_tab[i]) begin
            @(negedge clk);
            s_awaddr = dec_tab[i].addr; s_awvalid = 1;
            s0_awready = dec_tab[i].s0_rdy; s1_awready = dec_tab[i].s1_rdy;
            #1;
            check($sformatf("dec%0d.s0_awvalid", i), {31'd0, s0_awvalid}, {31'd0, dec_tab[i].exp_s0_v});
            check($sformatf("dec%0d.s1_awvalid", i), {31'd0, s1_awvalid}, {31'd0, dec_tab[i].exp_s1_v});
            check($sformatf("dec%0d.m_awready", i), {31'd0, m_awready}, {31'd0, dec_tab[i].exp_m_rdy});
            check($sformatf("dec%0d.idle_wb", i), {30'd0, m_wready, m_bvalid}, 32'd0);
            #1 clear_inputs();
        end

        // single-beat write to slave 0
        @(negedge clk);
        s_awaddr = 32'h0000_0040; s_awid = 0; s_awvalid = 1; s0_awready = 1;
        #1 check("t1.aw", {29'd0, s0_awvalid, m_awready, dbg_state == IDLE}, 32'd7);
        check_s1_quiet("t1.aw");
        @(negedge clk);
        clear_inputs(); s_wvalid = 1; s_wlast = 1; s0_wready = 1; s_awaddr = 32'h1000_0000;
        #1 check("t1.w", {29'd0, s0_wvalid, m_wready, m_awready}, 32'd6);
        check("t1.w_state", {30'd0, dbg_state}, DATA);
        check_s1_quiet("t1.w");
        @(negedge clk);
        clear_inputs(); s0_bvalid = 1; s0_bid = 0; s0_bresp = 2'b00; s_bready = 1;
        #1 check("t1.b", {27'd0, m_bvalid, m_bresp, m_bid, s0_bready}, {27'd0, 1'b1, 2'b00, 1'b0, 1'b1});
        check("t1.b_state", {30'd0, dbg_state}, RESP);
        check_s1_quiet("t1.b");
        @(negedge clk);
        clear_inputs();
        #1 check("t1.done", {29'd0, m_bvalid, dbg_state}, {29'd0, 1'b0, IDLE});

        // 4-beat burst to slave 1 with WREADY stalled on beat 2 for three cycles
        s_awaddr = 32'h1000_0100; s_awid = 1; s_awvalid = 1; s1_awready = 1;
        #1 check("t2.aw", {30'd0, s1_awvalid, m_awready}, 32'd3);
        hs = 0; beat = 0; stall = 3;
        for (int cyc = 0; cyc < 20 && beat < 4; cyc++) begin
            @(negedge clk);
            clear_inputs();
            s_awaddr = 32'h0000_0000;
            s_wvalid = 1; s_wlast = (beat == 3);
            if (beat == 1 && stall > 0) begin
                s1_wready = 0; stall--;
            end else begin
                s1_wready = 1;
            end
            #1;
            check($sformatf("t2.c%0d.state", cyc), {30'd0, dbg_state}, DATA);
            check($sformatf("t2.c%0d.wready", cyc), {31'd0, m_wready}, {31'd0, s1_wready});
            check_s0_quiet("t2");
            if (s1_wvalid && s1_wready) begin
                hs++; beat++;
            end
        end
        check("t2.w_handshakes", hs, 4);
        @(negedge clk);
        clear_inputs(); s1_bvalid = 1; s1_bid = 1; s1_bresp = 2'b00; s1_buser = 1; s_bready = 1;
        #1 check("t2.b", {26'd0, m_bvalid, m_bresp, m_bid, m_buser, s1_bready},
                 {26'd0, 1'b1, 2'b00, 1'b1, 1'b1, 1'b1});
        check("t2.b_state", {30'd0, dbg_state}, RESP);
        check_s0_quiet("t2.b");

        // decode miss: DECERR responder
        @(negedge clk);
        clear_inputs(); s_awaddr = 32'h2000_0000; s_awid = 1; s_awvalid = 1;
        #1 check("t3.aw", {31'd0, m_awready}, 32'd1);
        check_s0_quiet("t3.aw"); check_s1_quiet("t3.aw");
        for (int b = 0; b < 2; b++) begin
            @(negedge clk);
            clear_inputs(); s_wvalid = 1; s_wlast = (b == 1);
            #1 check($sformatf("t3.w%0d", b), {31'd0, m_wready}, 32'd1);
            check_s0_quiet("t3.w"); check_s1_quiet("t3.w");
        end
        @(negedge clk);
        clear_inputs(); s_bready = 1; s0_bvalid = 1; s0_bresp = 2'b00; s0_buser = 1;
        #1 check("t3.b", {27'd0, m_bvalid, m_bresp, m_bid, m_buser}, {27'd0, 1'b1, 2'b11, 1'b1, 1'b0});
        check_s0_quiet("t3.b"); check_s1_quiet("t3.b");

        // B backpressure with a second AW pending
        @(negedge clk);
        clear_inputs(); s_awaddr = 32'h0000_0100; s_awvalid = 1; s0_awready = 1;
        @(negedge clk);
        clear_inputs(); s_wvalid = 1; s_wlast = 1; s0_wready = 1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            clear_inputs();
            s0_bvalid = 1; s0_bresp = 2'b10; s0_bid = 0; s0_buser = 1;
            s_awaddr = 32'h1000_0000; s_awid = 1; s_awvalid = 1; s1_awready = 1;
            s_bready = (c == 5);
            #1 check($sformatf("t4.c%0d.b", c), {28'd0, m_bvalid, m_bresp, m_buser}, {28'd0, 1'b1, 2'b10, 1'b1});
            check($sformatf("t4.c%0d.aw", c), {28'd0, m_awready, s1_awvalid, dbg_state}, {28'd0, 2'b00, RESP});
            check($sformatf("t4.c%0d.bready", c), {31'd0, s0_bready}, {31'd0, s_bready});
        end
        @(negedge clk);
        s0_bvalid = 0; s_bready = 0;
        #1 check("t4.aw2", {28'd0, m_awready, s1_awvalid, dbg_state}, {28'd0, 2'b11, IDLE});
        check_s0_quiet("t4.aw2");

        // reset after 2 of 4 beats to slave 1
        @(negedge clk);
        clear_inputs(); s_wvalid = 1; s1_wready = 1;
        @(negedge clk);
        #1 check("t5.pre_reset_state", {30'd0, dbg_state}, DATA);
        @(negedge clk);
        rst_n = 0;
        s_awvalid = 1; s_awaddr = 32'h1000_0000; s1_awready = 1; s0_awready = 1;
        s_wvalid = 1; s_wlast = 1; s0_wready = 1; s1_wready = 1;
        s1_bvalid = 1; s0_bvalid = 1; s1_bresp = 2'b01; s1_bid = 1; s_bready = 1;
        #1 check("t5.in_reset0", all_outputs(), 32'd0);
        @(negedge clk);
        #1 check("t5.in_reset1", all_outputs(), 32'd0);
        @(negedge clk);
        clear_inputs(); rst_n = 1;
        #1 check("t5.released", {29'd0, m_bvalid, dbg_state}, {29'd0, 1'b0, IDLE});
        @(negedge clk);
        s_awaddr = 32'h0000_0000; s_awid = 0; s_awvalid = 1; s0_awready = 1;
        #1 check("t5.aw", {30'd0, s0_awvalid, m_awready}, 32'd3);
        check_s1_quiet("t5.aw");
        @(negedge clk);
        clear_inputs(); s_wvalid = 1; s_wlast = 1; s0_wready = 1;
        #1 check("t5.w", {30'd0, s0_wvalid, m_wready}, 32'd3);
        @(negedge clk);
        clear_inputs(); s0_bvalid = 1; s0_bresp = 2'b01; s_bready = 1;
        #1 check("t5.b", {28'd0, m_bvalid, m_bresp, s0_bready}, {28'd0, 1'b1, 2'b01, 1'b1});

        // W presented three cycles ahead of AW
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            clear_inputs(); s_wvalid = 1; s_wlast = 1; s0_wready = 1;
            #1 check($sformatf("t6.early%0d", c), {30'd0, m_wready, s0_wvalid}, 32'd0);
        end
        @(negedge clk);
        s_awaddr = 32'h0000_0200; s_awvalid = 1; s0_awready = 1;
        #1 check("t6.aw", {29'd0, m_awready, m_wready, s0_wvalid}, 32'd4);
        @(negedge clk);
        s_awvalid = 0; s0_awready = 0;
        #1 check("t6.w", {29'd0, m_wready, s0_wvalid, m_awready}, 32'd6);
        @(negedge clk);
        clear_inputs(); s0_bvalid = 1; s_bready = 1;
        #1 check("t6.b", {29'd0, m_bvalid, dbg_state}, {29'd0, 1'b1, RESP});
        @(negedge clk);
        clear_inputs();
        #1 check("t6.done", {30'd0, dbg_state}, IDLE);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
